// File: rtl/alu_pkg.sv
// Opcode constants and multiply state enum shared by the ALU control stage and the MULTU/HI-LO unit.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_AND    = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR     = 6'b100101;
    localparam logic [OP_W-1:0] OP_ADD    = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB    = 6'b100010;
    localparam logic [OP_W-1:0] OP_SLT    = 6'b101010;
    localparam logic [OP_W-1:0] OP_SLL    = 6'b000000;
    localparam logic [OP_W-1:0] OP_MULTU  = 6'b011001;
    localparam logic [OP_W-1:0] OP_FIRST  = 6'b111110;
    localparam logic [OP_W-1:0] OP_COMMIT = 6'b111111;
    localparam logic [OP_W-1:0] OP_MFHI   = 6'b010000;
    localparam logic [OP_W-1:0] OP_MFLO   = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/multu_hilo_unit_hilo_reg.sv
// HI/LO register pair, written as a unit on commit, with the MFHI/MFLO readback mux.
module hilo_reg
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [OP_W-1:0]  i_sel,
    output logic [WIDTH-1:0] o_data_c
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_we) begin
            r_hi <= i_hi;
            r_lo <= i_lo;
        end
    end

    // Readback is driven only while the matching move code is on the bus.
    always_comb begin
        o_data_c = '0;
        if (i_sel == OP_MFHI) begin
            o_data_c = r_hi;
        end else if (i_sel == OP_MFLO) begin
            o_data_c = r_lo;
        end
    end

endmodule

// File: rtl/multu_hilo_unit.sv
// Iterative unsigned shift-add multiplier (one step per MULTU code) feeding a committed HI/LO pair.
module multu_hilo_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             ready
);

    localparam int unsigned PW     = 2 * WIDTH + 1;
    localparam int unsigned STEP_W = $clog2(WIDTH + 1);

    mul_state_e        r_st;
    logic [PW-1:0]     r_p;
    logic [WIDTH-1:0]  r_m;
    logic [STEP_W-1:0] r_step;
    logic              r_busy;
    logic              r_ready;

    mul_state_e        w_nxt_st;
    logic [PW-1:0]     w_nxt_p;
    logic [WIDTH-1:0]  w_nxt_m;
    logic [STEP_W-1:0] w_nxt_step;
    logic              w_hilo_we;

    logic [PW-1:0]     w_src_p;
    logic [WIDTH-1:0]  w_src_m;
    logic [WIDTH:0]    w_sum;
    logic [PW-1:0]     w_acc;
    logic [PW-1:0]     w_stepped;

    // One multiply step; FIRST steps the freshly loaded operands instead of the held product.
    always_comb begin
        w_src_p = r_p;
        w_src_m = r_m;
        if (Signal == OP_FIRST) begin
            w_src_p = {1'b0, {WIDTH{1'b0}}, dataB};
            w_src_m = dataA;
        end
        w_sum = {1'b0, w_src_p[2*WIDTH-1:WIDTH]} + {1'b0, w_src_m};
        w_acc = w_src_p;
        if (w_src_p[0]) begin
            w_acc = {w_sum, w_src_p[WIDTH-1:0]};
        end
        w_stepped = w_acc >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st    <= ST_IDLE;
            r_p     <= '0;
            r_m     <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_st    <= w_nxt_st;
            r_p     <= w_nxt_p;
            r_m     <= w_nxt_m;
            r_step  <= w_nxt_step;
            r_busy  <= (w_nxt_st == ST_RUN);
            r_ready <= (w_nxt_st == ST_DONE);
        end
    end

    // FIRST restarts from any state; other codes only act in their owning state.
    always_comb begin
        w_nxt_st   = r_st;
        w_nxt_p    = r_p;
        w_nxt_m    = r_m;
        w_nxt_step = r_step;
        w_hilo_we  = 1'b0;
        if (Signal == OP_FIRST) begin
            w_nxt_p    = w_stepped;
            w_nxt_m    = dataA;
            w_nxt_step = STEP_W'(1);
            w_nxt_st   = (WIDTH == 1) ? ST_DONE : ST_RUN;
        end else begin
            unique case (r_st)
                ST_RUN: begin
                    if (Signal == OP_MULTU) begin
                        w_nxt_p    = w_stepped;
                        w_nxt_step = r_step + STEP_W'(1);
                        if (w_nxt_step == STEP_W'(WIDTH)) begin
                            w_nxt_st = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (Signal == OP_COMMIT) begin
                        w_hilo_we = 1'b1;
                        w_nxt_st  = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_hilo_we),
        .i_hi     (r_p[2*WIDTH-1:WIDTH]),
        .i_lo     (r_p[WIDTH-1:0]),
        .i_sel    (Signal),
        .o_data_c (dataOut)
    );

    assign busy  = r_busy;
    assign ready = r_ready;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Self-checking bench: behavioural MULTU/HI-LO model compared every cycle, plus directed literal checks.
module tb_multu_hilo_unit;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic [5:0]   Signal;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [W-1:0] dataOut;
    logic         busy;
    logic         ready;

    int n_checks = 0;
    int n_err    = 0;

    multu_hilo_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 running, 2 done; product computed directly by multiplication.
    int          m_mode;
    int          m_steps;
    logic [31:0] m_a, m_b, m_hi, m_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_steps <= 0; m_a <= 0; m_b <= 0; m_hi <= 0; m_lo <= 0;
        end else if (Signal == OP_FIRST) begin
            m_a <= dataA; m_b <= dataB; m_steps <= 1; m_mode <= 1;
        end else if (Signal == OP_MULTU && m_mode == 1) begin
            m_steps <= m_steps + 1;
            if (m_steps + 1 == 32) m_mode <= 2;
        end else if (Signal == OP_COMMIT && m_mode == 2) begin
            {m_hi, m_lo} <= 64'(m_a) * 64'(m_b);
            m_mode <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (Signal == OP_MFHI) ? m_hi : (Signal == OP_MFLO) ? m_lo : 32'h0;
        chk("model_busy",  64'(busy),    64'(m_mode == 1));
        chk("model_ready", 64'(ready),   64'(m_mode == 2));
        chk("model_dout",  64'(dataOut), 64'(exp_out));
    end

    // Present a code, let one edge sample it, return just after that edge.
    task automatic op(input logic [5:0] code, input logic [31:0] a = 32'h0, input logic [31:0] b = 32'h0);
        Signal = code; dataA = a; dataB = b;
        @(posedge clk); #1;
    endtask

    task automatic multu_n(input int n);
        for (int i = 0; i < n; i++) op(OP_MULTU);
    endtask

    task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        op(OP_MFHI); chk({name, "_hi"}, 64'(dataOut), 64'(hi));
        op(OP_MFLO); chk({name, "_lo"}, 64'(dataOut), 64'(lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [63:0] prod;
        logic [5:0]  fillers [4];
        int issued;
        fillers[0] = OP_ADD; fillers[1] = OP_SLL; fillers[2] = OP_MFHI; fillers[3] = OP_COMMIT;

        rst_n = 1'b0; Signal = OP_ADD; dataA = 0; dataB = 0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        read_hilo("reset", 32'h0, 32'h0);

        // Basic 3x5 with exact ready latency
        op(OP_FIRST, 32'd3, 32'd5);
        chk("basic_busy", 64'(busy), 64'd1);
        multu_n(30);
        chk("basic_ready_early", 64'(ready), 64'd0);
        op(OP_MULTU);
        chk("basic_ready_32", 64'(ready), 64'd1);
        chk("basic_busy_done", 64'(busy), 64'd0);
        op(OP_COMMIT);
        chk("basic_ready_clr", 64'(ready), 64'd0);
        read_hilo("basic", 32'h0, 32'h0000000F);

        // MULTU in IDLE has no effect
        multu_n(3);
        chk("idle_busy", 64'(busy), 64'd0);
        read_hilo("idle", 32'h0, 32'h0000000F);

        // Early commit, reads and pauses mid-run
        op(OP_FIRST, 32'h12345678, 32'h9ABCDEF0);
        multu_n(10);
        op(OP_COMMIT);
        chk("early_busy", 64'(busy), 64'd1);
        read_hilo("early", 32'h0, 32'h0000000F);
        op(OP_ADD); op(OP_ADD); op(OP_ADD);
        multu_n(20);
        chk("pause_ready_early", 64'(ready), 64'd0);
        op(OP_MULTU);
        chk("pause_ready", 64'(ready), 64'd1);
        multu_n(2);
        chk("done_hold_ready", 64'(ready), 64'd1);
        op(OP_COMMIT);
        read_hilo("pause", 32'h0B00EA4E, 32'h242D2080);

        // Max operands exercise the carry out of the upper add
        op(OP_FIRST, 32'hFFFFFFFF, 32'hFFFFFFFF);
        multu_n(31);
        op(OP_COMMIT);
        read_hilo("max", 32'hFFFFFFFE, 32'h00000001);

        // Restart discards the partial product
        op(OP_FIRST, 32'd7, 32'd9);
        multu_n(5);
        op(OP_FIRST, 32'd6, 32'd4);
        multu_n(31);
        op(OP_COMMIT);
        read_hilo("restart", 32'h0, 32'd24);

        // Reset mid-run after 10 steps
        op(OP_FIRST, 32'd11, 32'd13);
        multu_n(9);
        rst_n = 1'b0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        rst_n = 1'b1;
        read_hilo("rst", 32'h0, 32'h0);
        chk("rst_busy_after", 64'(busy), 64'd0);
        chk("rst_ready_after", 64'(ready), 64'd0);

        // Randomized runs with pauses, stray commits and extra MULTU after completion
        for (int t = 0; t < 24; t++) begin
            a = $urandom; b = $urandom;
            if (t == 0) a = 32'h0;
            if (t == 1) b = 32'h80000000;
            prod = 64'(a) * 64'(b);
            op(OP_FIRST, a, b);
            issued = 0;
            while (issued < 31) begin
                if ($urandom_range(0, 4) == 0) begin
                    op(fillers[$urandom_range(0, 3)]);
                end else begin
                    op(OP_MULTU);
                    issued++;
                end
            end
            multu_n(int'($urandom_range(0, 2)));
            op(OP_COMMIT);
            read_hilo("rand", prod[63:32], prod[31:0]);
        end

        op(OP_ADD);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
